// File: rtl/julia_iterator.sv
// Julia escape-time engine: iterates z <- z^2 + c in signed Q11.11 until |z|>2 or max_iter.
// Define JULIA_ITER_SATURATE_EN to saturate z updates instead of wrapping them.

module fixed_multiplication #(
  parameter int WIDTH      = 22,
  parameter int FRACTIONAL = 11
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);
  logic signed [2*WIDTH-1:0] full;
  logic                      unused_bits;

  assign full        = $signed(a) * $signed(b);
  // Dropping low bits of a two's complement product floors toward -inf.
  assign p           = full[WIDTH+FRACTIONAL-1:FRACTIONAL];
  assign unused_bits = ^{full[2*WIDTH-1:WIDTH+FRACTIONAL], full[FRACTIONAL-1:0]};
endmodule

// state | meaning
// IDLE  | waiting for start
// ITER  | one escape test / z update per cycle
// DONE  | results valid, done high; start here re-enters ITER
module julia_iterator #(
  parameter int WIDTH      = 22,
  parameter int FRACTIONAL = 11,
  parameter int ITER_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  z0_re,
  input  logic [WIDTH-1:0]  z0_im,
  input  logic [WIDTH-1:0]  c_re,
  input  logic [WIDTH-1:0]  c_im,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_count,
  output logic              escaped,
  output logic [WIDTH-1:0]  z_re_out,
  output logic [WIDTH-1:0]  z_im_out
);
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  localparam logic signed [WIDTH-1:0] TWO     = WIDTH'(1 << (FRACTIONAL + 1));
  localparam logic signed [WIDTH-1:0] NEG_TWO = -TWO;
  localparam logic signed [WIDTH:0]   FOUR    = (WIDTH+1)'(1 << (FRACTIONAL + 2));

  state_t                   state_q, state_d;
  logic signed [WIDTH-1:0]  zr_q, zr_d, zi_q, zi_d;
  logic signed [WIDTH-1:0]  cr_q, cr_d, ci_q, ci_d;
  logic [ITER_W-1:0]        max_q, max_d, cnt_q, cnt_d;
  logic [ITER_W-1:0]        iter_count_q, iter_count_d;
  logic                     escaped_q, escaped_d;
  logic [WIDTH-1:0]         z_re_out_q, z_re_out_d, z_im_out_q, z_im_out_d;

  logic [WIDTH-1:0]         zr2_u, zi2_u, zri_u;
  logic signed [WIDTH-1:0]  zr2, zi2, zri;
  logic signed [WIDTH:0]    sq_sum;
  logic signed [WIDTH+1:0]  zr_next_w, zi_next_w;
  logic signed [WIDTH-1:0]  zr_upd, zi_upd;
  logic                     esc;

  fixed_multiplication #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL)) u_mul_rr (
    .a(zr_q), .b(zr_q), .p(zr2_u));
  fixed_multiplication #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL)) u_mul_ii (
    .a(zi_q), .b(zi_q), .p(zi2_u));
  fixed_multiplication #(.WIDTH(WIDTH), .FRACTIONAL(FRACTIONAL)) u_mul_ri (
    .a(zr_q), .b(zi_q), .p(zri_u));

  assign zr2 = zr2_u;
  assign zi2 = zi2_u;
  assign zri = zri_u;

  // Squares are only trusted once both components are within +-2.0.
  assign sq_sum = $signed({zr2[WIDTH-1], zr2}) + $signed({zi2[WIDTH-1], zi2});
  assign esc    = (zr_q > TWO) || (zr_q < NEG_TWO) ||
                  (zi_q > TWO) || (zi_q < NEG_TWO) || (sq_sum > FOUR);

  assign zr_next_w = $signed({{2{zr2[WIDTH-1]}}, zr2}) - $signed({{2{zi2[WIDTH-1]}}, zi2})
                   + $signed({{2{cr_q[WIDTH-1]}}, cr_q});
  assign zi_next_w = $signed({zri[WIDTH-1], zri, 1'b0}) + $signed({{2{ci_q[WIDTH-1]}}, ci_q});

`ifdef JULIA_ITER_SATURATE_EN
  localparam logic signed [WIDTH+1:0] MAX_V = (WIDTH+2)'((64'sd1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [WIDTH+1:0] MIN_V = -(WIDTH+2)'(64'sd1 <<< (WIDTH - 1));

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH+1:0] v);
    if (v > MAX_V)      sat = MAX_V[WIDTH-1:0];
    else if (v < MIN_V) sat = MIN_V[WIDTH-1:0];
    else                sat = v[WIDTH-1:0];
  endfunction

  assign zr_upd = sat(zr_next_w);
  assign zi_upd = sat(zi_next_w);
`else
  logic unused_wrap_bits;

  assign zr_upd           = zr_next_w[WIDTH-1:0];
  assign zi_upd           = zi_next_w[WIDTH-1:0];
  assign unused_wrap_bits = ^{zr_next_w[WIDTH+1:WIDTH], zi_next_w[WIDTH+1:WIDTH]};
`endif

  always_comb begin
    state_d      = state_q;
    zr_d         = zr_q;
    zi_d         = zi_q;
    cr_d         = cr_q;
    ci_d         = ci_q;
    max_d        = max_q;
    cnt_d        = cnt_q;
    iter_count_d = iter_count_q;
    escaped_d    = escaped_q;
    z_re_out_d   = z_re_out_q;
    z_im_out_d   = z_im_out_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ITER;
          zr_d    = z0_re;
          zi_d    = z0_im;
          cr_d    = c_re;
          ci_d    = c_im;
          max_d   = max_iter;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        if (esc || (cnt_q == max_q)) begin
          state_d      = S_DONE;
          escaped_d    = esc;
          iter_count_d = cnt_q;
          z_re_out_d   = zr_q;
          z_im_out_d   = zi_q;
        end else begin
          zr_d  = zr_upd;
          zi_d  = zi_upd;
          cnt_d = cnt_q + ITER_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      zr_q         <= '0;
      zi_q         <= '0;
      cr_q         <= '0;
      ci_q         <= '0;
      max_q        <= '0;
      cnt_q        <= '0;
      iter_count_q <= '0;
      escaped_q    <= 1'b0;
      z_re_out_q   <= '0;
      z_im_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      zr_q         <= zr_d;
      zi_q         <= zi_d;
      cr_q         <= cr_d;
      ci_q         <= ci_d;
      max_q        <= max_d;
      cnt_q        <= cnt_d;
      iter_count_q <= iter_count_d;
      escaped_q    <= escaped_d;
      z_re_out_q   <= z_re_out_d;
      z_im_out_q   <= z_im_out_d;
    end
  end

  assign busy       = (state_q == S_ITER);
  assign done       = (state_q == S_DONE);
  assign iter_count = iter_count_q;
  assign escaped    = escaped_q;
  assign z_re_out   = z_re_out_q;
  assign z_im_out   = z_im_out_q;
endmodule
